// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions for the pixel generator and checker.
// Both sides take width, taps and next-state function from here so they cannot drift apart.
package lfsr_checker_pkg;

  localparam int unsigned LFSR_PIXEL_BITS = 24;
  localparam int unsigned LFSR_TAP_HI     = 12;
  localparam int unsigned LFSR_TAP_LO     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // XNOR feedback: the all-zeros word is a legal state, and the all-ones word is the lock-up state.
  function automatic logic [LFSR_PIXEL_BITS-1:0] lfsr_next(input logic [LFSR_PIXEL_BITS-1:0] x);
    return {x[LFSR_PIXEL_BITS-2:0], ~(x[LFSR_TAP_HI] ^ x[LFSR_TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr_cfg_regs.sv
// Seed/stop configuration register bank shared by the LFSR generator and checker.
// A write strobe stores into the selected register and is echoed one cycle later as done.
// Readback is combinational and follows the select input.
module lfsr_cfg_regs
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = LFSR_PIXEL_BITS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  config_i,
  input  logic                  config_rdy_i,
  input  logic [PIXEL_BITS-1:0] config_data_i,
  output logic                  config_done_o,
  output logic [PIXEL_BITS-1:0] config_data_o,
  output logic [PIXEL_BITS-1:0] seed_o,
  output logic [PIXEL_BITS-1:0] stop_o
);

  logic                  r_done;
  logic [PIXEL_BITS-1:0] r_seed;
  logic [PIXEL_BITS-1:0] r_stop;

  // Capture config writes and delay the write strobe into the done flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_done <= 1'b0;
      r_seed <= '0;
      r_stop <= '0;
    end else begin
      r_done <= config_rdy_i;
      if (config_rdy_i) begin
        if (config_i) begin
          r_stop <= config_data_i;
        end else begin
          r_seed <= config_data_i;
        end
      end
    end
  end

  assign config_done_o = r_done;
  assign config_data_o = config_i ? r_stop : r_seed;
  assign seed_o        = r_seed;
  assign stop_o        = r_stop;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR pixel checker.
// Regenerates the expected pixel sequence from the local seed and compares every accepted word.
// Counts accepted and mismatching words and reports completion once the stop word has been checked.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = LFSR_PIXEL_BITS,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  config_i,
  input  logic                  config_rdy_i,
  input  logic [PIXEL_BITS-1:0] config_data_i,
  output logic                  config_done_o,
  output logic [PIXEL_BITS-1:0] config_data_o,
  input  logic                  check_en_i,
  input  logic                  pix_valid_i,
  input  logic [PIXEL_BITS-1:0] pix_data_i,
  output logic                  mismatch_o,
  output logic [CNT_BITS-1:0]   err_count_o,
  output logic [CNT_BITS-1:0]   pix_count_o,
  output logic                  busy_o,
  output logic                  check_done_o
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [PIXEL_BITS-1:0] w_seed;
  logic [PIXEL_BITS-1:0] w_stop;
  logic [PIXEL_BITS-1:0] w_exp_next;

  chk_state_e            r_state;
  logic [PIXEL_BITS-1:0] r_exp;
  logic [CNT_BITS-1:0]   r_pix_cnt;
  logic [CNT_BITS-1:0]   r_err_cnt;
  logic                  r_mismatch;

  lfsr_cfg_regs #(
    .PIXEL_BITS(PIXEL_BITS)
  ) u_cfg_regs (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .config_i      (config_i),
    .config_rdy_i  (config_rdy_i),
    .config_data_i (config_data_i),
    .config_done_o (config_done_o),
    .config_data_o (config_data_o),
    .seed_o        (w_seed),
    .stop_o        (w_stop)
  );

  assign w_exp_next = lfsr_next(r_exp);

  // Checker FSM: track the expected word, accept and compare words, and maintain saturating counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_exp      <= '0;
      r_pix_cnt  <= '0;
      r_err_cnt  <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_exp <= w_seed;
          if (check_en_i) begin
            r_state   <= RUN;
            r_pix_cnt <= '0;
            r_err_cnt <= '0;
          end
        end
        RUN: begin
          // Dropping the enable takes priority over an accept in the same cycle, so that word is not counted.
          // A seed equal to the stop word ends the run before any word is accepted.
          if (!check_en_i) begin
            r_state <= IDLE;
          end else if (r_exp == w_stop) begin
            r_state <= DONE;
          end else if (pix_valid_i) begin
            r_exp <= w_exp_next;
            if (r_pix_cnt != '1) begin
              r_pix_cnt <= r_pix_cnt + CNT_ONE;
            end
            if (pix_data_i != w_exp_next) begin
              r_mismatch <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
              end
            end
            if (w_exp_next == w_stop) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (!check_en_i) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mismatch_o   = r_mismatch;
  assign err_count_o  = r_err_cnt;
  assign pix_count_o  = r_pix_cnt;
  assign busy_o       = (r_state == RUN);
  assign check_done_o = (r_state == DONE);

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side counterpart of the LFSR pixel generator. Consumes the 24-bit pixel stream qualified by a valid strobe and regenerates the expected sequence locally from its own seed/stop configuration. Compares every received word, counts words and mismatches, and flags completion when the expected stop word has been checked. Used in the test harness on the Sobel output path loopback and for self-test of the pixel pipeline.

## Interface
- `PIXEL_BITS`, 24: word width; must equal generator width.
- `CNT_BITS`, 16: width of word and error counters.
- `clk_i` in 1: clock, all logic on rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `config_i` in 1: register select (0 = seed, 1 = stop).
- `config_rdy_i` in 1: config write strobe.
- `config_data_i` in PIXEL_BITS: config write data.
- `config_done_o` out 1: `config_rdy_i` delayed one cycle.
- `config_data_o` out PIXEL_BITS: readback, stop_reg if `config_i` else seed_reg (combinational).
- `check_en_i` in 1: arm/run checker; low returns to IDLE.
- `pix_valid_i` in 1: received word valid.
- `pix_data_i` in PIXEL_BITS: received word.
- `mismatch_o` out 1: one-cycle pulse, previous accepted word was wrong.
- `err_count_o` out CNT_BITS: mismatching words, saturating.
- `pix_count_o` out CNT_BITS: accepted words, saturating.
- `busy_o` out 1: state == RUN.
- `check_done_o` out 1: state == DONE.

## Operation
- Next-state function `nxt(x)` = {x[22:0], x[12] XNOR x[3]}, identical to the generator.
- Config regs: on `config_rdy_i`, write seed_reg (`config_i`=0) or stop_reg (`config_i`=1). Writes are legal in any state. seed_reg is sampled only in IDLE. stop_reg is compared live.
- exp_q holds the last expected word.
- Expected value of the next received word = `nxt(exp_q)`.
- States: IDLE, RUN, DONE.
- IDLE:
  - exp_q <= seed_reg every cycle; `pix_valid_i` ignored; counters hold.
  - On `check_en_i`=1: go to RUN and clear both counters in the same edge.
- RUN, `check_en_i`=0: go to IDLE; counters hold their values.
- RUN, exp_q == stop_reg: go to DONE without accepting. This covers seed == stop, where the generator never emits.
- RUN, `pix_valid_i`=1 (accept):
  - pix_count++.
  - If `pix_data_i` != `nxt(exp_q)`: err_count++ and pulse `mismatch_o`.
  - exp_q <= `nxt(exp_q)` always; no resync on error.
- RUN, accepted word's expected value == stop_reg: go to DONE after the accept.
- DONE:
  - Valids ignored; exp_q and counters hold.
  - `check_en_i`=0: go to IDLE.
- Counters saturate at all-ones; never wrap.
- Reset:
  - All regs 0, state IDLE.
  - Outputs after reset: `config_done_o`=0, `mismatch_o`=0, both counts 0, `busy_o`=0, `check_done_o`=0, `config_data_o`=0.
  - Reset mid-RUN aborts immediately; nothing is retained.

## Timing
- Accept on the edge where RUN and `pix_valid_i`=1.
- `mismatch_o`, `pix_count_o` and `err_count_o` reflect that word on the following cycle (1-cycle latency).
- DONE is visible on `check_done_o` the cycle after the stop word is accepted.
- Throughput: one word per clock; back-to-back valids required to work; gaps in valid are allowed.
- Config write takes effect the edge after `config_rdy_i`. A write to seed_reg while in IDLE is used by the next RUN.
- Simultaneous config write and stop-word accept: the comparison uses the pre-write stop_reg.
- `check_en_i` falling on an accept cycle: go to IDLE, word not counted.

## Structure
- Shared package holds:
  - PIXEL_BITS
  - the LFSR tap positions (12, 3)
  - the state enum {IDLE, RUN, DONE}
  - a `lfsr_next` function, so generator and checker cannot diverge
- The config register bank (seed/stop write, done, readback) is a natural sub-module, `lfsr_cfg_regs`. The generator is to be refactored to instantiate it too.

## Test plan
- Seed 0x000001, stop 0x00001E, enable, then feed 03,07,0F,1E on consecutive cycles.
  - pix_count=4, err_count=0, `check_done_o`=1 one cycle after 1E, `mismatch_o` never high.
- Same config, third word sent as 0x00000E.
  - One `mismatch_o` pulse the cycle after it.
  - err_count=1, pix_count=4, DONE still reached after 1E.
- Seed 0, stop 0.
  - Enable goes to DONE within 2 cycles with both counts 0.
  - Seed 0 alone: first expected word is 0x000001.
- Valid gaps: same stream with valid low between words.
  - Identical counts; idle cycles are not counted.
- Drop `check_en_i` after 2 words.
  - IDLE, counts stay at 2.
  - Re-enable clears counts and restarts the check from the seed.
- Assert `reset_i` mid-RUN, and separately drive 2^16+5 errors with CNT_BITS=16.
  - Reset: all outputs 0 next cycle.
  - Errors: err_count holds 0xFFFF.
